// File: rtl/lab_pkg.sv
// -----------------------------------------------------------------------------
// lab_pkg
// Shared definitions for the lab push-button / counter / display blocks.
//   pb_state_e       : state encoding of the press/repeat pulse FSM
//   SAMPLE_DIV_BOARD : debounce sample divider used on the real board
//                      (one sample per millisecond at 100 MHz)
//   max2()           : elaboration-time helper for sizing counters
// -----------------------------------------------------------------------------
package lab_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } pb_state_e;

  localparam int SAMPLE_DIV_BOARD = 100000;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pb_sync_debounce.sv
// -----------------------------------------------------------------------------
// pb_sync_debounce
// Synchronises an asynchronous, bouncing level and debounces it by sampling
// once every SAMPLE_DIV clocks into a DEB_LEN-deep window. The debounced level
// only changes once the whole window agrees. Reusable for any slow manual
// input (push buttons, mode switches).
//
// Ports:
//   clk_i    : clock
//   rst_n_i  : asynchronous active-low reset
//   raw_i    : raw level, asynchronous to clk_i
//   deb_o    : registered debounced level
//   tick_o   : one-cycle sample strobe (high when the divider is at its last count)
//   rise_o   : high in the cycle whose edge will take deb_o from 0 to 1
//   fall_o   : high in the cycle whose edge will take deb_o from 1 to 0
// -----------------------------------------------------------------------------
module pb_sync_debounce #(
  parameter int SAMPLE_DIV = 4,
  parameter int DEB_LEN    = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic raw_i,
  output logic deb_o,
  output logic tick_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int                CNT_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  logic                sync1_q, sync2_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DEB_LEN-1:0]  win_q, win_d;
  logic                deb_q, deb_d;
  logic                tick;

  // Two-flop synchroniser; only sync2_q is safe to use downstream.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    win_d = win_q;
    deb_d = deb_q;
    if (tick) begin
      win_d = {win_q[DEB_LEN-2:0], sync2_q};
      // Level changes only when every sample in the window agrees;
      // a mixed window holds the previous level.
      if (&win_d) begin
        deb_d = 1'b1;
      end else if (~|win_d) begin
        deb_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      win_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      win_q <= win_d;
      deb_q <= deb_d;
    end
  end

  // Edge strobes are taken from the next-state value so the consumer can act
  // on the very edge that updates deb_o.
  assign deb_o  = deb_q;
  assign tick_o = tick;
  assign rise_o = deb_d & ~deb_q;
  assign fall_o = ~deb_d & deb_q;

endmodule

// File: rtl/pb_debounce_pulse.sv
// -----------------------------------------------------------------------------
// pb_debounce_pulse
// Push-button front end for the lab BCD counters. The raw button is
// synchronised and debounced, then a small FSM turns each press into a single
// one-cycle increment pulse pb_l, with optional hold-to-repeat.
//
// Ports:
//   clk          : clock
//   rst_n        : asynchronous active-low reset
//   pb_in        : raw button level, active high, asynchronous to clk
//   pb_debounced : registered debounced level
//   pb_l         : registered one-cycle press / repeat pulse
//   long_press   : high while the FSM is in REPEAT
//
// Timing (in sample ticks of SAMPLE_DIV clocks):
//   first pulse on the tick the debounced level rises;
//   first repeat REPEAT_DELAY ticks later, then one every REPEAT_RATE ticks.
// -----------------------------------------------------------------------------
module pb_debounce_pulse
  import lab_pkg::*;
#(
  parameter int SAMPLE_DIV   = 4,
  parameter int DEB_LEN      = 4,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_in,
  output logic pb_debounced,
  output logic pb_l,
  output logic long_press
);

  localparam int                 HOLD_MAX   = max2(REPEAT_DELAY, REPEAT_RATE);
  localparam int                 HOLD_W     = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0]  DELAY_LAST = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0]  RATE_LAST  = HOLD_W'(REPEAT_RATE - 1);
  localparam logic [HOLD_W-1:0]  HOLD_SAT   = HOLD_W'(HOLD_MAX);

  logic              deb;
  logic              tick;
  logic              deb_rise;
  logic              deb_fall;

  pb_state_e         state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              pb_l_q, pb_l_d;
  logic              long_press_q, long_press_d;

  pb_sync_debounce #(
    .SAMPLE_DIV (SAMPLE_DIV),
    .DEB_LEN    (DEB_LEN)
  ) u_sync_debounce (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .raw_i   (pb_in),
    .deb_o   (deb),
    .tick_o  (tick),
    .rise_o  (deb_rise),
    .fall_o  (deb_fall)
  );

  // The hold counter counts sample ticks spent in the current state. Expiry is
  // detected one count early (== LAST) so that the pulse lands exactly on the
  // REPEAT_DELAY-th / REPEAT_RATE-th tick and the counter never reaches past
  // HOLD_MAX.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pb_l_d  = 1'b0;

    if (deb_fall) begin
      // Release has priority over a repeat expiring on the same tick.
      state_d = IDLE;
      hold_d  = '0;
    end else if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (deb_rise) begin
            state_d = PRESSED;
            hold_d  = '0;
            pb_l_d  = 1'b1;
          end
        end
        PRESSED: begin
          if ((REPEAT_EN != 0) && (hold_q == DELAY_LAST)) begin
            state_d = REPEAT;
            hold_d  = '0;
            pb_l_d  = 1'b1;
          end else if (hold_q != HOLD_SAT) begin
            // Saturates when repeat is disabled and the button stays held.
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        REPEAT: begin
          if (hold_q == RATE_LAST) begin
            hold_d = '0;
            pb_l_d = 1'b1;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          hold_d  = '0;
        end
      endcase
    end

    long_press_d = (state_d == REPEAT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      pb_l_q       <= 1'b0;
      long_press_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      pb_l_q       <= pb_l_d;
      long_press_q <= long_press_d;
    end
  end

  assign pb_debounced = deb;
  assign pb_l         = pb_l_q;
  assign long_press   = long_press_q;

endmodule
